round_timer_ctrl: RTL and testbench
===================================

# round_timer_ctrl

Sequencing controller for the 16-bit up/down loadable counter, which the Quick Add game uses as its round timer. It loads a preset time, decrements it once every TICKS_PER_STEP quarter-second ticks, and honours pause, abort and bonus-time requests. It reports warning and expiry to the game FSM. The counter instance sits beside this block: this block drives its din/ld/up/dw inputs and observes its q/utc/dtc outputs.

## Interface
- TICKS_PER_STEP, 4: tick_in pulses per one-count decrement (4 = 1 s at qsec ticks); legal range 1..15
- WARN_LEVEL, 16'd5: warn_out is asserted while the count is at or below this value and nonzero
- clk_in  in  1  system clock
- reset_in  in  1  reset, synchronous, active-high
- start_in  in  1  pulse; latch preset_in, then load and run
- pause_in  in  1  level; freeze the countdown while high
- abort_in  in  1  pulse; return to IDLE
- bonus_in  in  1  pulse; add one count
- tick_in  in  1  one-cycle qsec timebase pulse
- preset_in  [15:0]  in  16  round time; sampled on start_in
- cnt_q_in  [15:0]  in  16  counter value
- cnt_utc_in  in  1  counter at 16'hFFFF
- cnt_dtc_in  in  1  counter at 16'h0000
- cnt_din_out  [15:0]  out  16  load value (latched preset)
- cnt_ld_out  out  1  counter load strobe
- cnt_up_out  out  1  counter increment strobe
- cnt_dw_out  out  1  counter decrement strobe
- state_out  [2:0]  out  3  current state encoding
- warn_out  out  1  low-time warning
- expired_out  out  1  level; high while in EXPIRED
- done_pulse_out  out  1  one-cycle pulse on entry to EXPIRED

## Operation
- States and encodings: IDLE=0, LOAD=1, RUN=2, PAUSE=3, EXPIRED=4. Encodings 5–7 are illegal and recover to IDLE on the next cycle.
- Event priority, high to low: reset_in > abort_in > start_in > pause_in > tick/bonus.
- IDLE: no strobes. start_in -> LOAD and latch preset_in into the preset register.
- start_in in RUN, PAUSE or EXPIRED restarts the round: re-latch preset_in -> LOAD. start_in in LOAD is ignored.
- LOAD: lasts one cycle. cnt_ld_out=1 and cnt_din_out=preset register. Next state is RUN, or EXPIRED directly if the preset register is 0. The prescaler clears.
- RUN:
  - Each tick_in increments the prescaler.
  - On the tick where the prescaler equals TICKS_PER_STEP-1, the prescaler clears and a decrement request is raised.
  - A decrement request is dropped if cnt_dtc_in=1, or if cnt_dw_out=1 and cnt_q_in=1 (stale-zero guard).
  - A bonus_in request is dropped if cnt_utc_in=1 (saturate at FFFF).
  - A decrement and a bonus in the same cycle cancel: no strobe is issued, and the prescaler still clears.
  - cnt_dtc_in=1 while no cnt_up_out is pending -> EXPIRED.
  - pause_in=1 -> PAUSE; requests in that cycle are dropped.
- PAUSE: no strobes, prescaler frozen, tick_in and bonus_in ignored. pause_in=0 -> RUN.
- EXPIRED: no strobes; expired_out=1. done_pulse_out=1 only in the first EXPIRED cycle.
- abort_in in any state -> IDLE. Pending strobes are cancelled and the prescaler clears.
- warn_out = (state is RUN or PAUSE) & (cnt_q_in <= WARN_LEVEL) & ~cnt_dtc_in. The comparison is unsigned 16-bit.
- Reset values: state IDLE, prescaler 0, preset register 0, every output 0.

## Timing
- State, prescaler, preset register, cnt_up_out, cnt_dw_out and done_pulse_out are registered.
- cnt_ld_out, cnt_din_out, state_out, expired_out and warn_out decode from registered state and inputs.
- Start latency: start_in high in cycle N -> LOAD in N+1 (cnt_ld_out high) -> counter shows preset and state is RUN in N+2.
- Step latency: qualifying tick_in in cycle T -> cnt_dw_out high in T+1 -> decremented cnt_q_in visible in T+2.
- Expiry latency: cnt_dtc_in first high in cycle E while in RUN -> EXPIRED and done_pulse_out in E+1.
- Strobes are one cycle wide. At most one of cnt_ld_out, cnt_up_out and cnt_dw_out is high in any cycle.
- reset_in mid-round: all outputs are 0 the next cycle. The counter value is left as-is, and the next start reloads it.

## Test plan
- Basic round: reset, preset_in=3, start, tick every 4 cycles, TICKS_PER_STEP=4 -> cnt_ld_out in cycle 1; a cnt_dw_out after every 4th tick; q goes 3,2,1,0; EXPIRED with one done_pulse_out; 12 ticks in total.
- Pause/resume: preset 10, pause after 2 decrements and feed 20 ticks while paused -> no strobes and q holds 8. Release pause -> the prescaler resumes from its frozen value.
- Bonus and saturation: preset FFFE, two bonus_in pulses -> one cnt_up_out (to FFFF), then dropped. A bonus coinciding with a qualifying tick -> no strobes and the prescaler clears.
- Zero and warning: preset 0 -> LOAD then EXPIRED immediately, with no dw strobe. Preset 7, WARN_LEVEL=5 -> warn_out rises when q=5 and falls at q=0.
- Abort and restart: abort in RUN -> IDLE next cycle with no strobes. start during PAUSE with preset 20 -> LOAD, then q=20 and RUN.
- Reset mid-round in RUN with cnt_dw_out pending -> next cycle state_out=0, all strobes and flags 0.

Source files
------------

// File: rtl/round_timer_ctrl.sv
// rtl/round_timer_ctrl.sv - round timer sequencing controller for a 16-bit up/down counter
//
// Purpose: loads a preset round time into the adjacent counter, steps it down
// once every TICKS_PER_STEP tick pulses, and handles pause, abort and bonus.
// Reports low-time warning and expiry to the game FSM.
//
// Ports:
//   clk_in, reset_in         clock, synchronous active-high reset
//   start_in, abort_in       pulse requests (restart round / return to idle)
//   pause_in                 level; freeze countdown while high
//   bonus_in                 pulse; add one count
//   tick_in                  one-cycle timebase pulse
//   preset_in[15:0]          round time, sampled on start_in
//   cnt_q_in/utc/dtc         observed counter value and terminal flags
//   cnt_din/ld/up/dw_out     counter load value and strobes
//   state_out[2:0]           current state encoding
//   warn_out, expired_out    status levels
//   done_pulse_out           one-cycle pulse on entry to EXPIRED
module round_timer_ctrl #(
  parameter int unsigned TICKS_PER_STEP = 4,
  parameter logic [15:0] WARN_LEVEL     = 16'd5
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        start_in,
  input  logic        pause_in,
  input  logic        abort_in,
  input  logic        bonus_in,
  input  logic        tick_in,
  input  logic [15:0] preset_in,
  input  logic [15:0] cnt_q_in,
  input  logic        cnt_utc_in,
  input  logic        cnt_dtc_in,
  output logic [15:0] cnt_din_out,
  output logic        cnt_ld_out,
  output logic        cnt_up_out,
  output logic        cnt_dw_out,
  output logic [2:0]  state_out,
  output logic        warn_out,
  output logic        expired_out,
  output logic        done_pulse_out
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_EXPIRED = 3'd4
  } state_e;

  localparam logic [3:0] PRESC_MAX = 4'(TICKS_PER_STEP - 1);

  state_e      state_q, state_d;
  logic [3:0]  presc_q, presc_d;
  logic [15:0] preset_q, preset_d;
  logic        up_q, up_d;
  logic        dw_q, dw_d;
  logic        done_q, done_d;

  logic        dec_req;
  logic        dec_ok;
  logic        bonus_ok;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q  <= ST_IDLE;
      presc_q  <= 4'd0;
      preset_q <= 16'd0;
      up_q     <= 1'b0;
      dw_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      preset_q <= preset_d;
      up_q     <= up_d;
      dw_q     <= dw_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    preset_d = preset_q;
    up_d     = 1'b0;
    dw_d     = 1'b0;
    done_d   = 1'b0;
    dec_req  = 1'b0;
    dec_ok   = 1'b0;
    bonus_ok = 1'b0;

    if (abort_in) begin
      // Strobe registers default to 0, so any pending request is cancelled.
      state_d = ST_IDLE;
      presc_d = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            preset_d = preset_in;
            state_d  = ST_LOAD;
          end
        end

        ST_LOAD: begin
          presc_d = 4'd0;
          if (preset_q == 16'd0) begin
            state_d = ST_EXPIRED;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end

        ST_RUN: begin
          if (start_in) begin
            preset_d = preset_in;
            state_d  = ST_LOAD;
          end else if (pause_in) begin
            state_d = ST_PAUSE;
          end else if (cnt_dtc_in && !up_q) begin
            // A pending increment means the zero seen now is about to change.
            state_d = ST_EXPIRED;
            done_d  = 1'b1;
          end else begin
            if (tick_in) begin
              if (presc_q == PRESC_MAX) begin
                presc_d = 4'd0;
                dec_req = 1'b1;
              end else begin
                presc_d = presc_q + 4'd1;
              end
            end
            // cnt_q_in still shows 1 while a decrement is in flight; it is
            // really 0 already, so a second decrement would wrap.
            dec_ok   = dec_req && !cnt_dtc_in && !(dw_q && (cnt_q_in == 16'd1));
            bonus_ok = bonus_in && !cnt_utc_in;
            up_d     = bonus_ok && !dec_ok;
            dw_d     = dec_ok && !bonus_ok;
          end
        end

        ST_PAUSE: begin
          if (start_in) begin
            preset_d = preset_in;
            state_d  = ST_LOAD;
          end else if (!pause_in) begin
            state_d = ST_RUN;
          end
        end

        ST_EXPIRED: begin
          if (start_in) begin
            preset_d = preset_in;
            state_d  = ST_LOAD;
          end
        end

        default: begin
          state_d = ST_IDLE;
          presc_d = 4'd0;
        end
      endcase
    end
  end

  assign cnt_din_out    = preset_q;
  assign cnt_ld_out     = (state_q == ST_LOAD);
  assign cnt_up_out     = up_q;
  assign cnt_dw_out     = dw_q;
  assign state_out      = state_q;
  assign expired_out    = (state_q == ST_EXPIRED);
  assign done_pulse_out = done_q;
  assign warn_out       = ((state_q == ST_RUN) || (state_q == ST_PAUSE)) &&
                          (cnt_q_in <= WARN_LEVEL) && !cnt_dtc_in;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// tb/tb_round_timer_ctrl.sv - self-checking bench for round_timer_ctrl with a counter model
module tb_round_timer_ctrl;

  localparam int TPS = 4;
  localparam logic [3:0] K_LD = 4'b1000;
  localparam logic [3:0] K_UP = 4'b0100;
  localparam logic [3:0] K_DW = 4'b0010;
  localparam logic [3:0] K_DN = 4'b0001;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic        start_in = 1'b0;
  logic        pause_in = 1'b0;
  logic        abort_in = 1'b0;
  logic        bonus_in = 1'b0;
  logic        tick_in = 1'b0;
  logic [15:0] preset_in = 16'd0;
  logic [15:0] cnt_q = 16'd0;
  logic        cnt_utc;
  logic        cnt_dtc;
  logic [15:0] cnt_din_out;
  logic        cnt_ld_out;
  logic        cnt_up_out;
  logic        cnt_dw_out;
  logic [2:0]  state_out;
  logic        warn_out;
  logic        expired_out;
  logic        done_pulse_out;

  int n_chk = 0;
  int n_fail = 0;

  logic [19:0] exp_q[$];
  logic [15:0] qm;
  int          ptick;
  bit          exp_run;

  round_timer_ctrl #(.TICKS_PER_STEP(TPS), .WARN_LEVEL(16'd5)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in), .pause_in(pause_in),
    .abort_in(abort_in), .bonus_in(bonus_in), .tick_in(tick_in), .preset_in(preset_in),
    .cnt_q_in(cnt_q), .cnt_utc_in(cnt_utc), .cnt_dtc_in(cnt_dtc),
    .cnt_din_out(cnt_din_out), .cnt_ld_out(cnt_ld_out), .cnt_up_out(cnt_up_out),
    .cnt_dw_out(cnt_dw_out), .state_out(state_out), .warn_out(warn_out),
    .expired_out(expired_out), .done_pulse_out(done_pulse_out)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural model of the adjacent 16-bit up/down loadable counter.
  always @(posedge clk_in) begin
    if (cnt_ld_out)      cnt_q <= cnt_din_out;
    else if (cnt_up_out) cnt_q <= cnt_q + 16'd1;
    else if (cnt_dw_out) cnt_q <= cnt_q - 16'd1;
  end
  assign cnt_utc = (cnt_q == 16'hFFFF);
  assign cnt_dtc = (cnt_q == 16'h0000);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [3:0] k, input logic [15:0] v);
    exp_q.push_back({k, v});
  endtask

  // Scoreboard consumer: every strobe or done pulse must match the next expectation.
  always @(negedge clk_in) begin
    logic [3:0]  obs_k;
    logic [15:0] obs_v;
    logic [19:0] e;
    if (cnt_ld_out || cnt_up_out || cnt_dw_out || done_pulse_out) begin
      obs_k = {cnt_ld_out, cnt_up_out, cnt_dw_out, done_pulse_out};
      obs_v = cnt_ld_out ? cnt_din_out : cnt_q;
      chk("sb_expected_event", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_kind", 32'(obs_k), 32'(e[19:16]));
        chk("sb_value", 32'(obs_v), 32'(e[15:0]));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic gap3();
    cyc(); cyc(); cyc();
  endtask

  task automatic tick_once();
    if (exp_run) begin
      ptick++;
      if (ptick == TPS) begin
        ptick = 0;
        push(K_DW, qm);
        qm = qm - 16'd1;
        if (qm == 16'd0) push(K_DN, 16'd0);
      end
    end
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] val);
    preset_in = val;
    start_in  = 1'b1;
    pause_in  = 1'b0;
    push(K_LD, val);
    if (val == 16'd0) push(K_DN, 16'd0);
    qm = val;
    ptick = 0;
    exp_run = 1'b1;
    cyc();
    start_in = 1'b0;
    chk("load_state", 32'(state_out), 32'd1);
    chk("load_ld", 32'(cnt_ld_out), 32'd1);
    chk("load_din", 32'(cnt_din_out), 32'(val));
    cyc();
  endtask

  initial begin
    qm = 16'd0;
    ptick = 0;
    exp_run = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("reset_outputs", {cnt_din_out, cnt_ld_out, cnt_up_out, cnt_dw_out, state_out,
                          warn_out, expired_out, done_pulse_out}, 32'd0);
    reset_in = 1'b0;
    cyc();
    chk("idle_state", 32'(state_out), 32'd0);

    // Basic round: preset 3, 12 ticks
    do_start(16'd3);
    chk("basic_run", 32'(state_out), 32'd2);
    chk("basic_q3", 32'(cnt_q), 32'd3);
    for (int i = 0; i < 12; i++) begin
      tick_once();
      gap3();
    end
    chk("basic_q0", 32'(cnt_q), 32'd0);
    chk("basic_expired_state", 32'(state_out), 32'd4);
    chk("basic_expired_out", 32'(expired_out), 32'd1);
    chk("basic_done_low", 32'(done_pulse_out), 32'd0);
    chk("basic_warn_low", 32'(warn_out), 32'd0);

    // Pause / resume
    do_start(16'd10);
    for (int i = 0; i < 10; i++) begin
      tick_once();
      gap3();
    end
    chk("pause_pre_q", 32'(cnt_q), 32'd8);
    pause_in = 1'b1;
    exp_run = 1'b0;
    cyc();
    chk("pause_state", 32'(state_out), 32'd3);
    for (int i = 0; i < 20; i++) begin
      tick_in  = 1'b1;
      bonus_in = (i % 5 == 0);
      cyc();
      tick_in  = 1'b0;
      bonus_in = 1'b0;
      cyc();
    end
    chk("pause_q_hold", 32'(cnt_q), 32'd8);
    chk("pause_state_hold", 32'(state_out), 32'd3);
    pause_in = 1'b0;
    cyc();
    chk("resume_state", 32'(state_out), 32'd2);
    exp_run = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick_once();
      gap3();
    end
    chk("resume_q", 32'(cnt_q), 32'd7);

    // Bonus and saturation
    do_start(16'hFFFE);
    push(K_UP, 16'hFFFE);
    bonus_in = 1'b1; cyc(); bonus_in = 1'b0; cyc(); cyc();
    chk("bonus_q_ffff", 32'(cnt_q), 32'hFFFF);
    bonus_in = 1'b1; cyc(); bonus_in = 1'b0; cyc(); cyc();
    chk("bonus_saturate", 32'(cnt_q), 32'hFFFF);
    qm = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      tick_once();
      gap3();
    end
    chk("bonus_dec_q", 32'(cnt_q), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      tick_once();
      gap3();
    end
    tick_in = 1'b1; bonus_in = 1'b1;
    cyc();
    tick_in = 1'b0; bonus_in = 1'b0;
    ptick = 0;
    chk("cancel_no_strobe", 32'({cnt_up_out, cnt_dw_out}), 32'd0);
    gap3();
    chk("cancel_q", 32'(cnt_q), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      tick_once();
      gap3();
    end
    chk("cancel_presc_cleared", 32'(cnt_q), 32'hFFFE);
    tick_once();
    gap3();
    chk("cancel_then_dec", 32'(cnt_q), 32'hFFFD);

    // Zero preset
    do_start(16'd0);
    chk("zero_expired", 32'(state_out), 32'd4);
    chk("zero_done", 32'(done_pulse_out), 32'd1);
    cyc();
    chk("zero_done_once", 32'(done_pulse_out), 32'd0);
    chk("zero_expired_out", 32'(expired_out), 32'd1);

    // Warning window with preset 7
    do_start(16'd7);
    chk("warn_q7", 32'(warn_out), 32'd0);
    for (int s = 0; s < 7; s++) begin
      for (int i = 0; i < 3; i++) begin
        tick_once();
        gap3();
      end
      tick_once();
      cyc();
      chk("warn_step_q", 32'(cnt_q), 32'(qm));
      chk("warn_step_state", 32'(state_out), 32'd2);
      chk("warn_step_level", 32'(warn_out), 32'((qm <= 16'd5) && (qm != 16'd0)));
      cyc(); cyc();
    end
    chk("warn_end_expired", 32'(state_out), 32'd4);

    // Abort and restart
    do_start(16'd30);
    for (int i = 0; i < 3; i++) begin
      tick_once();
      gap3();
    end
    tick_in = 1'b1; abort_in = 1'b1;
    cyc();
    tick_in = 1'b0; abort_in = 1'b0;
    ptick = 0;
    chk("abort_idle", 32'(state_out), 32'd0);
    chk("abort_no_strobe", 32'({cnt_ld_out, cnt_up_out, cnt_dw_out}), 32'd0);
    cyc();
    chk("abort_stays_idle", 32'(state_out), 32'd0);
    do_start(16'd30);
    pause_in = 1'b1;
    cyc();
    chk("restart_pause", 32'(state_out), 32'd3);
    do_start(16'd20);
    chk("restart_run", 32'(state_out), 32'd2);
    chk("restart_q20", 32'(cnt_q), 32'd20);

    // Reset mid-round with a decrement pending
    for (int i = 0; i < 3; i++) begin
      tick_once();
      gap3();
    end
    tick_once();
    chk("pre_reset_dw", 32'(cnt_dw_out), 32'd1);
    reset_in = 1'b1;
    cyc();
    chk("midreset_outputs", {cnt_din_out, cnt_ld_out, cnt_up_out, cnt_dw_out, state_out,
                             warn_out, expired_out, done_pulse_out}, 32'd0);
    reset_in = 1'b0;
    cyc(); cyc();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
